sfu_lane_seq: RTL and testbench
===============================

SFU_LANE_SEQ -- requirements
Module: sfu_lane_seq

Interface
REQ-001 SHALL have parameter NUM_LANES, default 8, number of operand lanes per request.
REQ-002 SHALL have parameter DATA_W, default 32, per-lane operand/result width.
REQ-003 SHALL have parameter OP_W, default 3, operation-select width.
REQ-004 SHALL have port clk_i  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  in  1  request strobe, sampled only in IDLE.
REQ-007 SHALL have port selop_i  in  OP_W  operation code (sin, cos, rsqrt, log2, ex2, ...).
REQ-008 SHALL have port src_i  in  NUM_LANES*DATA_W  lane operands; lane n at bits [n*DATA_W +: DATA_W].
REQ-009 SHALL have port mask_i  in  NUM_LANES  active-lane mask.
REQ-010 SHALL have port stall_o  out  1  sequencer busy.
REQ-011 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-012 SHALL have port result_o  out  NUM_LANES*DATA_W  lane results, same packing as src_i.
REQ-013 SHALL have port core_start_o  out  1  one-cycle start to the scalar SFU core.
REQ-014 SHALL have ports core_selop_o (out, OP_W) and core_src_o (out, DATA_W)  operation code and operand to the core.
REQ-015 SHALL have ports core_result_i (in, DATA_W) and core_stall_i (in, 1)  core result and core busy.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: start_i=1 SHALL capture src_i, selop_i and mask_i, and zero all result lanes; next state DONE if mask_i==0, else ISSUE.
REQ-018 start_i in any state other than IDLE SHALL be ignored.
REQ-019 ISSUE: SHALL select the lowest-indexed set bit of the pending mask, drive core_start_o=1, core_src_o=that lane's operand and core_selop_o=captured op for exactly one cycle, then enter WAIT.
REQ-020 WAIT: core_stall_i is examined from the cycle after core_start_o; the first cycle with core_stall_i==0 SHALL write core_result_i into the selected lane and clear its pending bit.
REQ-021 After that write, next state SHALL be DONE if the pending mask is now zero, else ISSUE.
REQ-022 Zero-latency cores (core_stall_i never high) SHALL give exactly 2 cycles per active lane.
REQ-023 stall_o SHALL be 1 in ISSUE and WAIT and 0 in IDLE and DONE.
REQ-024 done_o SHALL be 1 only in DONE; DONE SHALL return to IDLE after one cycle.
REQ-025 Latency: start sampled at cycle 0 with K active lanes and zero core stall SHALL give done_o at cycle 2K+1; K=0 SHALL give done_o at cycle 1.
REQ-026 Inactive lanes SHALL read 0 on result_o.
REQ-027 result_o SHALL hold stable from DONE until the next accepted start.
REQ-028 core_selop_o and core_src_o SHALL hold their values while in WAIT.
REQ-029 The datapath SHALL treat lane data as opaque DATA_W bits, with no arithmetic.

Reset
REQ-030 rst_i=1 at a clock edge SHALL force: state IDLE; stall_o, done_o and core_start_o 0; result and pending-mask registers 0.
REQ-031 Reset mid-operation SHALL abandon the request; a core result arriving after reset SHALL be ignored, and no done_o SHALL be produced for the abandoned request.

Structure
REQ-032 Shared package sfu_pkg SHALL hold opcode constants SFU_SIN=0, SFU_COS=1, SFU_RSQRT=2, SFU_LOG2=3, SFU_EX2=4 and the FSM state typedef.
REQ-033 Lowest-set-bit selection SHALL be one sub-module, sfu_lane_pick, parametrised by NUM_LANES, outputting index and valid.

Verification (NUM_LANES=4, DATA_W=32)
REQ-034 Full mask: mask=4'b1111, op RSQRT, all lanes 0x3F800000, zero-stall core model returning 0x3F800000 -> 4 core starts; done_o at cycle 9; all lanes 0x3F800000.
REQ-035 Sparse mask: mask=4'b0101 -> core starts only for lanes 0 and 2; done_o at cycle 5; lanes 1 and 3 read 0.
REQ-036 Empty mask: mask=4'b0000 -> no core_start_o; done_o at cycle 1; stall_o never high.
REQ-037 Variable core latency: op SIN, core stalls 17 cycles per lane, mask=4'b0011 -> each result captured on the first core_stall_i==0 cycle; done_o at cycle 39.
REQ-038 Busy and reset: start_i pulsed while in WAIT -> ignored. Then rst_i asserted during lane 1 of a 4'b1111 request -> stall_o=0 next cycle; no done_o; next request completes correctly.

Source files
------------

// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU lane sequencer: opcode values and FSM states.
package sfu_pkg;

    localparam int unsigned SFU_SIN   = 0;
    localparam int unsigned SFU_COS   = 1;
    localparam int unsigned SFU_RSQRT = 2;
    localparam int unsigned SFU_LOG2  = 3;
    localparam int unsigned SFU_EX2   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } sfu_state_e;

endpackage

// File: rtl/sfu_lane_pick.sv
// Lowest-set-bit picker: returns the index of the lowest active lane and whether any lane is set.
module sfu_lane_pick #(
    parameter int NUM_LANES = 8,
    parameter int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0] mask,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    always_comb begin
        idx   = '0;
        valid = |mask;
        // scanning downward leaves the lowest set bit as the final winner
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sfu_lane_seq.sv
// Serialises a multi-lane SFU request onto a single scalar SFU core, one active lane at a time.
//
// state | meaning
// IDLE  | waiting for start_i; captures operands, op and mask
// ISSUE | one-cycle core_start_o for the lowest pending lane
// WAIT  | waiting for core_stall_i==0, then writes the lane result
// DONE  | one-cycle done_o, results held until next accepted start
module sfu_lane_seq
    import sfu_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int DATA_W    = 32,
    parameter int OP_W      = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [OP_W-1:0]             selop_i,
    input  logic [NUM_LANES*DATA_W-1:0] src_i,
    input  logic [NUM_LANES-1:0]        mask_i,
    output logic                        stall_o,
    output logic                        done_o,
    output logic [NUM_LANES*DATA_W-1:0] result_o,
    output logic                        core_start_o,
    output logic [OP_W-1:0]             core_selop_o,
    output logic [DATA_W-1:0]           core_src_o,
    input  logic [DATA_W-1:0]           core_result_i,
    input  logic                        core_stall_i
);

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    sfu_state_e                  state_q, state_d;
    logic [NUM_LANES*DATA_W-1:0] src_q;
    logic [NUM_LANES*DATA_W-1:0] result_q;
    logic [OP_W-1:0]             op_q;
    logic [NUM_LANES-1:0]        pending_q;
    logic [NUM_LANES-1:0]        pick_onehot;
    logic [NUM_LANES-1:0]        pending_left;
    logic [IDX_W-1:0]            pick_idx;
    logic                        pick_valid;
    logic                        accept;
    logic                        lane_write;

    sfu_lane_pick #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_pick (
        .mask  (pending_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // pending is untouched between ISSUE and WAIT, so the picked lane stays stable across both
    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
        pending_left          = pending_q & ~pick_onehot;
        accept                = (state_q == ST_IDLE) && start_i;
        lane_write            = (state_q == ST_WAIT) && !core_stall_i;
        state_d               = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (mask_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = pick_valid ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                if (!core_stall_i) begin
                    state_d = (pending_left == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            op_q      <= '0;
            pending_q <= '0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_q     <= src_i;
                op_q      <= selop_i;
                pending_q <= mask_i;
                result_q  <= '0;
            end
            if (lane_write) begin
                result_q[pick_idx*DATA_W +: DATA_W] <= core_result_i;
                pending_q                           <= pending_left;
            end
        end
    end

    assign stall_o      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign done_o       = (state_q == ST_DONE);
    assign core_start_o = (state_q == ST_ISSUE);
    assign core_selop_o = op_q;
    assign core_src_o   = src_q[pick_idx*DATA_W +: DATA_W];
    assign result_o     = result_q;

endmodule

// File: tb/tb_sfu_lane_seq.sv
// Scoreboard bench for sfu_lane_seq with a behavioural scalar core of programmable latency.
module tb_sfu_lane_seq;
    import sfu_pkg::*;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int OW = 3;

    typedef struct {
        logic [NL*DW-1:0] res;
        int               cyc;
        int               starts;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [OW-1:0]     selop_i;
    logic [NL*DW-1:0]  src_i;
    logic [NL-1:0]     mask_i;
    logic              stall_o;
    logic              done_o;
    logic [NL*DW-1:0]  result_o;
    logic              core_start_o;
    logic [OW-1:0]     core_selop_o;
    logic [DW-1:0]     core_src_o;
    logic [DW-1:0]     core_result_i = '0;
    logic              core_stall_i;

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                n_starts = 0;
    int                stall_left = 0;
    int                lat = 0;
    logic [DW-1:0]     key = '0;
    logic [OW+DW-1:0]  last_core = '0;
    exp_t              exp_q[$];
    logic [OW+DW-1:0]  core_q[$];

    sfu_lane_seq #(
        .NUM_LANES (NL),
        .DATA_W    (DW),
        .OP_W      (OW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .selop_i       (selop_i),
        .src_i         (src_i),
        .mask_i        (mask_i),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .result_o      (result_o),
        .core_start_o  (core_start_o),
        .core_selop_o  (core_selop_o),
        .core_src_o    (core_src_o),
        .core_result_i (core_result_i),
        .core_stall_i  (core_stall_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // scalar core: result = operand ^ key, busy for `lat` cycles after each start
    always @(posedge clk_i) begin
        if (core_start_o) begin
            core_result_i <= core_src_o ^ key;
            stall_left    <= lat;
        end else if (stall_left > 0) begin
            stall_left <= stall_left - 1;
        end
    end
    assign core_stall_i = (stall_left != 0);

    task automatic chk(input string name, input logic [NL*DW-1:0] got, input logic [NL*DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // monitor: core issues against the expected lane order, completions against the result queue
    always @(negedge clk_i) begin
        if (rst_i) begin
            n_starts = 0;
        end else begin
            if (core_start_o) begin
                n_starts++;
                last_core = {core_selop_o, core_src_o};
                if (core_q.size() == 0) begin
                    chk("unexpected_core_start", 1, 0);
                end else begin
                    chk("core_op_src", {core_selop_o, core_src_o}, core_q.pop_front());
                end
            end else if (stall_o) begin
                chk("core_hold_in_wait", {core_selop_o, core_src_o}, last_core);
            end
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", result_o, e.res);
                    chk("done_cycle", cyc, e.cyc);
                    chk("core_starts", n_starts, e.starts);
                end
                n_starts = 0;
            end
        end
    end

    task automatic run_req(input logic [OW-1:0] op, input logic [NL*DW-1:0] src,
                           input logic [NL-1:0] mask, input int l, input logic [DW-1:0] k);
        exp_t e;
        int   n = 0;
        int   t = 0;
        bit   saw_stall = 0;
        e.res = '0;
        lat = l;
        key = k;
        for (int i = 0; i < NL; i++) begin
            if (mask[i]) begin
                e.res[i*DW +: DW] = src[i*DW +: DW] ^ k;
                core_q.push_back({op, src[i*DW +: DW]});
                n++;
            end
        end
        e.starts = n;
        e.cyc    = cyc + n * (2 + l) + 1;
        exp_q.push_back(e);
        selop_i = op;
        src_i   = src;
        mask_i  = mask;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        src_i   = ~src;
        mask_i  = ~mask;
        while (!done_o && t < 2000) begin
            if (stall_o) saw_stall = 1;
            @(negedge clk_i);
            t++;
        end
        chk("done_seen", done_o, 1);
        if (n == 0) chk("stall_never_high", saw_stall, 0);
        repeat (3) @(negedge clk_i);
        chk("result_hold", result_o, e.res);
    endtask

    initial begin
        int dones;
        rst_i   = 1'b1;
        start_i = 1'b0;
        selop_i = '0;
        src_i   = '0;
        mask_i  = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_stall", stall_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_core_start", core_start_o, 0);
        chk("rst_result", result_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // full mask, zero-latency core returning 1.0f
        run_req(3'(SFU_RSQRT), {4{32'h3F80_0000}}, 4'b1111, 0, 32'h0);
        // sparse mask
        run_req(3'(SFU_COS), {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                4'b0101, 0, 32'h0F0F_0000);
        // empty mask
        run_req(3'(SFU_SIN), {4{32'hFFFF_FFFF}}, 4'b0000, 0, 32'h0);
        // 17-cycle core latency
        run_req(3'(SFU_SIN), {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hBBBB_0002, 32'hAAAA_0001},
                4'b0011, 17, 32'h00FF_00FF);
        // single highest lane
        run_req(3'(SFU_LOG2), {32'hCAFE_F00D, 32'h1, 32'h2, 32'h3}, 4'b1000, 1, 32'h0);

        // busy start ignored, then reset during lane 1
        lat = 17;
        key = 32'h5555_5555;
        core_q.push_back({3'(SFU_EX2), 32'h0000_00A0});
        core_q.push_back({3'(SFU_EX2), 32'h0000_00A1});
        selop_i = 3'(SFU_EX2);
        src_i   = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        mask_i  = 4'b1111;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        selop_i = 3'(SFU_COS);
        src_i   = '1;
        mask_i  = 4'b0000;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (18) @(negedge clk_i);
        chk("busy_before_reset", stall_o, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("reset_stall", stall_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_result", result_o, 0);
        dones = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        chk("abandoned_no_done", dones, 0);

        // request after reset
        run_req(3'(SFU_EX2), {32'h0BAD_0004, 32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001},
                4'b1010, 2, 32'h1234_5678);

        chk("exp_queue_empty", exp_q.size(), 0);
        chk("core_queue_empty", core_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
